// File: rtl/i2c_master_pkg.sv
// Shared encodings for the I2C master engine: FSM states, quarter phases and bus bit values.
package i2c_master_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDRW, ACK1, OFFS, ACK2, WDATA, ACK3,
        RSTART, ADDRR, ACK4, RDATA, MACK, STOP
    } stateT;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic isTxByteState(input stateT s);
        return (s == ADDRW) || (s == OFFS) || (s == WDATA) || (s == ADDRR);
    endfunction

endpackage

// File: rtl/i2c_scl_tick_gen.sv
// Quarter-period timebase: one tick every QDIV clocks plus a 2-bit quarter phase.
// clear parks the timebase at phase Q0; hold freezes it (used for clock stretching).
module i2c_scl_tick_gen #(
    parameter int QDIV = 1
) (
    input  logic       iClk,
    input  logic       iRstn,
    input  logic       clear,
    input  logic       hold,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [CW-1:0] count;

    assign tick = !clear && !hold && (count == CW'(QDIV - 1));

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            count <= '0;
            phase <= 2'd0;
        end else if (clear) begin
            count <= '0;
            phase <= 2'd0;
        end else if (!hold) begin
            if (tick) begin
                count <= '0;
                phase <= phase + 2'd1;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_master_engine.sv
// Byte-level I2C initiator: register write / register read with repeated START.
// Define I2C_CLK_STRETCH_EN to let a target stretch SCL during the Q1 high phase.
module i2c_master_engine
    import i2c_master_pkg::*;
#(
    parameter int CLK_FREQ_KHZ = 50000,
    parameter int SCL_FREQ_KHZ = 100
) (
    input  logic       iClk,
    input  logic       iRstn,
    input  logic       iStart,
    input  logic       iRnW,
    input  logic [6:0] ivSlaveAddr,
    input  logic [7:0] ivOffset,
    input  logic [3:0] ivByteCnt,
    input  logic [7:0] ivTxData,
    output logic       oTxNext,
    output logic [7:0] ovRxData,
    output logic       oRxValid,
    input  logic       iSCL,
    input  logic       iSDA,
    output logic       oSCLoe,
    output logic       oSDAoe,
    output logic       oBusy,
    output logic       oDone,
    output logic       oNack
);

    localparam int QDIV_RAW = CLK_FREQ_KHZ / (4 * SCL_FREQ_KHZ);
    localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;

    stateT state, stateNext, entryState;
    logic [2:0] bitIdx, bitIdxNext;
    logic [7:0] shiftReg, shiftNext, offs, offsNext, rxData, rxDataNext;
    logic [6:0] addr, addrNext;
    logic [3:0] byteCnt, byteCntNext;
    logic rnw, rnwNext, sampled, sampledNext;
    logic sclOe, sclOeNext, sdaOe, sdaOeNext, nack, nackNext;
    logic rxValid, rxValidNext, txNext, txNextNext, done, doneNext;
    logic tick, holdQuarter;
    logic [1:0] phase;

`ifdef I2C_CLK_STRETCH_EN
    assign holdQuarter = (state != IDLE) && (phase == Q1) && sclOe && !iSCL;
`else
    logic unusedScl;
    assign unusedScl   = iSCL;
    assign holdQuarter = 1'b0;
`endif

    i2c_scl_tick_gen #(.QDIV(QDIV)) tickGen (
        .iClk  (iClk),
        .iRstn (iRstn),
        .clear (state == IDLE),
        .hold  (holdQuarter),
        .tick  (tick),
        .phase (phase)
    );

    // All line changes happen on quarter ticks; the case on phase is the quarter being left.
    always_comb begin
        stateNext   = state;
        entryState  = state;
        bitIdxNext  = bitIdx;
        shiftNext   = shiftReg;
        byteCntNext = byteCnt;
        rnwNext     = rnw;
        addrNext    = addr;
        offsNext    = offs;
        sampledNext = sampled;
        sclOeNext   = sclOe;
        sdaOeNext   = sdaOe;
        rxDataNext  = rxData;
        nackNext    = nack;
        rxValidNext = 1'b0;
        txNextNext  = 1'b0;
        doneNext    = 1'b0;

        if (state == IDLE) begin
            sclOeNext = 1'b1;
            sdaOeNext = 1'b1;
            if (iStart) begin
                stateNext   = START;
                rnwNext     = iRnW;
                addrNext    = ivSlaveAddr;
                offsNext    = ivOffset;
                byteCntNext = (iRnW && ivByteCnt == 4'd0) ? 4'd1 : ivByteCnt;
                nackNext    = 1'b0;
            end
        end else if (state == STOP && done) begin
            stateNext = IDLE;
        end else if (tick) begin
            unique case (phase)
                Q0: begin
                    if (state == START) sdaOeNext = 1'b0;
                    else                sclOeNext = 1'b1;
                end
                Q1: begin
                    sampledNext = iSDA;
                    case (state)
                        START:  sclOeNext = 1'b0;
                        RSTART: sdaOeNext = 1'b0;
                        STOP: begin
                            sdaOeNext = 1'b1;
                            doneNext  = 1'b1;
                        end
                        RDATA: begin
                            shiftNext = {shiftReg[6:0], iSDA};
                            if (bitIdx == 3'd0) begin
                                rxDataNext  = {shiftReg[6:0], iSDA};
                                rxValidNext = 1'b1;
                                byteCntNext = byteCnt - 4'd1;
                            end
                        end
                        ACK1, ACK2, ACK3, ACK4: begin
                            if (iSDA == NACK_BIT) nackNext = 1'b1;
                        end
                        default: ;
                    endcase
                end
                Q2: sclOeNext = 1'b0;
                Q3: begin
                    sclOeNext = 1'b0;
                    if ((isTxByteState(state) || state == RDATA) && bitIdx != 3'd0) begin
                        bitIdxNext = bitIdx - 3'd1;
                        if (state == RDATA) begin
                            sdaOeNext = 1'b1;
                        end else begin
                            shiftNext = {shiftReg[6:0], shiftReg[7]};
                            sdaOeNext = shiftReg[6];
                        end
                    end else begin
                        case (state)
                            START:  entryState = ADDRW;
                            ADDRW:  entryState = ACK1;
                            ACK1:   entryState = (sampled == NACK_BIT) ? STOP : OFFS;
                            OFFS:   entryState = ACK2;
                            ACK2: begin
                                if (sampled == NACK_BIT)    entryState = STOP;
                                else if (rnw == RW_READ)    entryState = RSTART;
                                else if (byteCnt == 4'd0)   entryState = STOP;
                                else                        entryState = WDATA;
                            end
                            WDATA:  entryState = ACK3;
                            ACK3:   entryState = (sampled == NACK_BIT || byteCnt == 4'd0) ? STOP : WDATA;
                            RSTART: entryState = ADDRR;
                            ADDRR:  entryState = ACK4;
                            ACK4:   entryState = (sampled == NACK_BIT) ? STOP : RDATA;
                            RDATA:  entryState = MACK;
                            MACK:   entryState = (byteCnt == 4'd0) ? STOP : RDATA;
                            default: entryState = STOP;
                        endcase
                        stateNext  = entryState;
                        bitIdxNext = 3'd7;
                        // Q0 of the new state: present its first SDA value while SCL is low.
                        case (entryState)
                            ADDRW: begin
                                shiftNext = {addr, RW_WRITE};
                                sdaOeNext = addr[6];
                            end
                            OFFS: begin
                                shiftNext = offs;
                                sdaOeNext = offs[7];
                            end
                            WDATA: begin
                                shiftNext   = ivTxData;
                                sdaOeNext   = ivTxData[7];
                                txNextNext  = 1'b1;
                                byteCntNext = byteCnt - 4'd1;
                            end
                            ADDRR: begin
                                shiftNext = {addr, RW_READ};
                                sdaOeNext = addr[6];
                            end
                            MACK:    sdaOeNext = (byteCnt == 4'd0) ? NACK_BIT : ACK_BIT;
                            STOP:    sdaOeNext = 1'b0;
                            default: sdaOeNext = 1'b1;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state    <= IDLE;
            bitIdx   <= 3'd7;
            shiftReg <= 8'h00;
            byteCnt  <= 4'd0;
            rnw      <= RW_WRITE;
            addr     <= 7'h00;
            offs     <= 8'h00;
            sampled  <= 1'b0;
            sclOe    <= 1'b1;
            sdaOe    <= 1'b1;
            rxData   <= 8'h00;
            nack     <= 1'b0;
            rxValid  <= 1'b0;
            txNext   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= stateNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            byteCnt  <= byteCntNext;
            rnw      <= rnwNext;
            addr     <= addrNext;
            offs     <= offsNext;
            sampled  <= sampledNext;
            sclOe    <= sclOeNext;
            sdaOe    <= sdaOeNext;
            rxData   <= rxDataNext;
            nack     <= nackNext;
            rxValid  <= rxValidNext;
            txNext   <= txNextNext;
            done     <= doneNext;
        end
    end

    assign oSCLoe   = sclOe;
    assign oSDAoe   = sdaOe;
    assign oBusy    = (state != IDLE);
    assign oDone    = done;
    assign oNack    = nack;
    assign oTxNext  = txNext;
    assign oRxValid = rxValid;
    assign ovRxData = rxData;

endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed bench for i2c_master_engine with a behavioural I2C target at address 0x08 on a wired-AND bus.
module tb_i2c_master_engine;

    logic       iClk = 1'b0;
    logic       iRstn = 1'b0;
    logic       iStart = 1'b0;
    logic       iRnW = 1'b0;
    logic [6:0] ivSlaveAddr = 7'h00;
    logic [7:0] ivOffset = 8'h00;
    logic [3:0] ivByteCnt = 4'd0;
    logic [7:0] ivTxData;
    logic       oTxNext, oRxValid, oSCLoe, oSDAoe, oBusy, oDone, oNack;
    logic [7:0] ovRxData;
    logic       iSCL, iSDA;
    logic       slvScl = 1'b1;
    logic       slvSda = 1'b1;

    int testsRun = 0;
    int testsFailed = 0;

    assign iSCL = oSCLoe & slvScl;
    assign iSDA = oSDAoe & slvSda;

    always #5 iClk = ~iClk;

    i2c_master_engine #(.CLK_FREQ_KHZ(4000), .SCL_FREQ_KHZ(100)) dut (
        .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iRnW(iRnW),
        .ivSlaveAddr(ivSlaveAddr), .ivOffset(ivOffset), .ivByteCnt(ivByteCnt),
        .ivTxData(ivTxData), .oTxNext(oTxNext), .ovRxData(ovRxData), .oRxValid(oRxValid),
        .iSCL(iSCL), .iSDA(iSDA), .oSCLoe(oSCLoe), .oSDAoe(oSDAoe),
        .oBusy(oBusy), .oDone(oDone), .oNack(oNack)
    );

    // Write-data source: the byte after each oTxNext pulse is the next table entry.
    logic [7:0] txBytes [16];
    int txNextCount = 0, rxCount = 0, doneCount = 0;
    int txBase = 0, doneBase = 0, rxBase = 0;
    logic [7:0] rxLog [64];
    assign ivTxData = txBytes[4'(txNextCount - txBase)];

    always @(negedge iClk) begin
        if (oTxNext) txNextCount++;
        if (oRxValid) begin
            rxLog[rxCount % 64] = ovRxData;
            rxCount++;
        end
        if (oDone) doneCount++;
    end

    // Behavioural target: samples the bus on the falling clock edge, acts on SCL/SDA edges.
    logic [6:0] slvAddr = 7'h08;
    logic [7:0] readMem [256];
    logic       prevScl = 1'b1, prevSda = 1'b1;
    logic       slvActive = 1'b0, slvAckSlot = 1'b0, slvTx = 1'b0, slvPendTx = 1'b0, masterAcked = 1'b0;
    logic       stretchEnable = 1'b0;
    int         slvBitCnt = 0, slvByteIdx = 0, stretchLeft = 0;
    logic [7:0] slvShift = 8'h00, slvPtr = 8'h00, slvTxByte = 8'h00;
    logic [7:0] logAddr = 8'h00, logOffset = 8'h00, logData = 8'h00, ackLog = 8'h00;
    int         logStarts = 0, logStops = 0, logWrites = 0, sclRises = 0, ackSlots = 0;

    always @(negedge iClk) begin
        if (stretchLeft > 0) begin
            stretchLeft--;
            if (stretchLeft == 0) slvScl = 1'b1;
        end
        if (prevScl && iSCL && prevSda && !iSDA) begin
            slvActive = 1'b1; slvAckSlot = 1'b0; slvTx = 1'b0; slvPendTx = 1'b0;
            slvBitCnt = 0; slvByteIdx = 0; slvSda = 1'b1;
            logStarts++;
        end else if (prevScl && iSCL && !prevSda && iSDA) begin
            slvActive = 1'b0; slvAckSlot = 1'b0; slvTx = 1'b0; slvSda = 1'b1;
            logStops++;
        end else if (!prevScl && iSCL) begin
            sclRises++;
            if (slvActive) begin
                if (slvAckSlot) begin
                    if (slvTx) begin
                        masterAcked = !iSDA;
                        ackLog = {ackLog[6:0], iSDA};
                        ackSlots++;
                    end
                end else begin
                    slvShift = {slvShift[6:0], iSDA};
                    slvBitCnt++;
                end
            end
        end else if (prevScl && !iSCL && slvActive) begin
            if (slvAckSlot) begin
                slvAckSlot = 1'b0; slvSda = 1'b1; slvBitCnt = 0;
                if (stretchEnable && !slvTx && !slvPendTx && slvByteIdx == 1) begin
                    slvScl = 1'b0;
                    stretchLeft = 500;
                end
                if (slvPendTx) begin
                    slvTx = 1'b1; slvPendTx = 1'b0; masterAcked = 1'b1;
                end
                if (slvTx) begin
                    if (masterAcked) begin
                        slvTxByte = readMem[slvPtr];
                        slvPtr++;
                        slvSda = slvTxByte[7];
                    end else begin
                        slvActive = 1'b0; slvTx = 1'b0;
                    end
                end
            end else if (slvBitCnt == 8) begin
                slvAckSlot = 1'b1;
                if (slvTx) begin
                    slvSda = 1'b1;
                end else if (slvByteIdx == 0) begin
                    if (slvShift[7:1] == slvAddr) begin
                        slvSda = 1'b0;
                        logAddr = {1'b0, slvShift[7:1]};
                        slvPendTx = slvShift[0];
                    end else begin
                        slvActive = 1'b0; slvAckSlot = 1'b0;
                    end
                    slvByteIdx++;
                end else if (slvByteIdx == 1) begin
                    slvPtr = slvShift; logOffset = slvShift; slvSda = 1'b0;
                    slvByteIdx++;
                end else begin
                    logData = slvShift; logWrites++; slvPtr++; slvSda = 1'b0;
                    slvByteIdx++;
                end
            end else if (slvTx) begin
                slvSda = slvTxByte[7 - slvBitCnt];
            end
        end
        prevScl = iSCL;
        prevSda = iSDA;
    end

    int startBase = 0, stopBase = 0, riseBase = 0, writeBase = 0, ackBase = 0;
    int lastCycles = 0, baseCycles = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic launch(input logic rnw, input logic [6:0] addr, input logic [7:0] offs, input logic [3:0] cnt);
        @(negedge iClk);
        txBase = txNextCount; doneBase = doneCount; rxBase = rxCount;
        startBase = logStarts; stopBase = logStops; riseBase = sclRises;
        writeBase = logWrites; ackBase = ackSlots;
        iRnW = rnw; ivSlaveAddr = addr; ivOffset = offs; ivByteCnt = cnt; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    task automatic applyStimulus(input logic rnw, input logic [6:0] addr, input logic [7:0] offs, input logic [3:0] cnt);
        int cycles;
        launch(rnw, addr, offs, cnt);
        cycles = 1;
        while ((doneCount - doneBase) == 0 && cycles < 20000) begin
            @(negedge iClk);
            cycles++;
        end
        lastCycles = cycles;
        checkOutput("doneSeen", doneCount - doneBase, 1);
        @(negedge iClk);
        checkOutput("busyAfterDone", oBusy, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) txBytes[i] = 8'h00;
        for (int i = 0; i < 256; i++) readMem[i] = 8'hFF;
        readMem[8'h00] = 8'h23;
        readMem[8'h20] = 8'h11;
        readMem[8'h21] = 8'h22;
        readMem[8'h22] = 8'h33;

        #23;
        checkOutput("resetSCLoe", oSCLoe, 1);
        checkOutput("resetSDAoe", oSDAoe, 1);
        checkOutput("resetBusy", oBusy, 0);
        checkOutput("resetNack", oNack, 0);
        checkOutput("resetDone", oDone, 0);
        checkOutput("resetRxData", ovRxData, 8'h00);
        @(negedge iClk);
        iRstn = 1'b1;
        repeat (3) @(negedge iClk);

        // Single-byte write, with a stray command strobe while busy.
        txBytes[0] = 8'h5A;
        fork
            applyStimulus(1'b0, 7'h08, 8'h10, 4'd1);
            begin
                repeat (300) @(negedge iClk);
                iRnW = 1'b1; ivSlaveAddr = 7'h55; iStart = 1'b1;
                @(negedge iClk);
                iStart = 1'b0; iRnW = 1'b0;
            end
        join
        baseCycles = lastCycles;
        checkOutput("wrAddr", logAddr, 8'h08);
        checkOutput("wrOffset", logOffset, 8'h10);
        checkOutput("wrData", logData, 8'h5A);
        checkOutput("wrWrites", logWrites - writeBase, 1);
        checkOutput("wrTxNext", txNextCount - txBase, 1);
        checkOutput("wrNack", oNack, 0);
        checkOutput("wrStarts", logStarts - startBase, 1);
        checkOutput("wrStops", logStops - stopBase, 1);

        // Single-byte read through repeated START.
        applyStimulus(1'b1, 7'h08, 8'h00, 4'd1);
        checkOutput("rdStarts", logStarts - startBase, 2);
        checkOutput("rdData", ovRxData, 8'h23);
        checkOutput("rdValid", rxCount - rxBase, 1);
        checkOutput("rdAckSlots", ackSlots - ackBase, 1);
        checkOutput("rdLastNack", ackLog[0], 1);
        checkOutput("rdNack", oNack, 0);

        // Absent target: NACK on the address byte, straight to STOP.
        txBytes[0] = 8'hA5;
        applyStimulus(1'b0, 7'h09, 8'h10, 4'd2);
        checkOutput("absNack", oNack, 1);
        checkOutput("absTxNext", txNextCount - txBase, 0);
        checkOutput("absSclRises", sclRises - riseBase, 10);
        checkOutput("absStops", logStops - stopBase, 1);

        // Three-byte read: ACK, ACK, NACK from the master.
        applyStimulus(1'b1, 7'h08, 8'h20, 4'd3);
        checkOutput("rd3Nack", oNack, 0);
        checkOutput("rd3Valid", rxCount - rxBase, 3);
        checkOutput("rd3Byte0", rxLog[rxBase % 64], 8'h11);
        checkOutput("rd3Byte1", rxLog[(rxBase + 1) % 64], 8'h22);
        checkOutput("rd3Byte2", rxLog[(rxBase + 2) % 64], 8'h33);
        checkOutput("rd3AckSlots", ackSlots - ackBase, 3);
        checkOutput("rd3AckPattern", ackLog[2:0], 3'b001);

        // Zero-length write: address and offset only.
        applyStimulus(1'b0, 7'h08, 8'h40, 4'd0);
        checkOutput("wr0Offset", logOffset, 8'h40);
        checkOutput("wr0Writes", logWrites - writeBase, 0);
        checkOutput("wr0TxNext", txNextCount - txBase, 0);
        checkOutput("wr0SclRises", sclRises - riseBase, 19);

        // Reset in the middle of a data byte.
        txBytes[0] = 8'h00;
        txBytes[1] = 8'h00;
        launch(1'b0, 7'h08, 8'h50, 4'd2);
        for (int i = 0; i < 5000 && (txNextCount - txBase) == 0; i++) @(negedge iClk);
        checkOutput("midTxNext", txNextCount - txBase, 1);
        repeat (50) @(negedge iClk);
        #2 iRstn = 1'b0;
        #1;
        checkOutput("midRstSCLoe", oSCLoe, 1);
        checkOutput("midRstSDAoe", oSDAoe, 1);
        checkOutput("midRstBusy", oBusy, 0);
        @(negedge iClk);
        iRstn = 1'b1;
        repeat (5) @(negedge iClk);

        txBytes[0] = 8'hC3;
        applyStimulus(1'b0, 7'h08, 8'h30, 4'd1);
        checkOutput("postRstOffset", logOffset, 8'h30);
        checkOutput("postRstData", logData, 8'hC3);
        checkOutput("postRstWrites", logWrites - writeBase, 1);
        checkOutput("postRstNack", oNack, 0);

`ifdef I2C_CLK_STRETCH_EN
        // Target holds SCL low for 500 clocks after the address ACK.
        txBytes[0] = 8'h7E;
        stretchEnable = 1'b1;
        applyStimulus(1'b0, 7'h08, 8'h10, 4'd1);
        stretchEnable = 1'b0;
        checkOutput("strData", logData, 8'h7E);
        checkOutput("strOffset", logOffset, 8'h10);
        checkOutput("strNack", oNack, 0);
        checkOutput("strExtend", ((lastCycles - baseCycles) >= 450) && ((lastCycles - baseCycles) <= 510), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
